// File: rtl/calc_if.sv
// Client, result and datapath signals between calc_arbiter and its environment.
// The err line exists only when CALC_NEGZERO_CHK_EN is defined.
interface calc_if;
    logic       req0, req1;
    logic [2:0] a0, a1, b0, b1;
    logic       op0, op1;
    logic       ack0, ack1, done0, done1;
    logic [4:0] res;
    logic       busy;
    logic [2:0] dp_a, dp_b;
    logic       dp_s;
    logic [4:0] dp_c;
`ifdef CALC_NEGZERO_CHK_EN
    logic       err;
`endif

    modport slave (
        input  req0, req1, a0, a1, b0, b1, op0, op1, dp_c,
`ifdef CALC_NEGZERO_CHK_EN
        output err,
`endif
        output ack0, ack1, done0, done1, res, busy, dp_a, dp_b, dp_s
    );

    modport master (
        output req0, req1, a0, a1, b0, b1, op0, op1, dp_c,
`ifdef CALC_NEGZERO_CHK_EN
        input  err,
`endif
        input  ack0, ack1, done0, done1, res, busy, dp_a, dp_b, dp_s
    );
endinterface

// File: rtl/calc_arbiter.sv
// Two-client arbiter/sequencer for the shared sign-magnitude add/sub datapath.
// Define CALC_NEGZERO_CHK_EN to reject negative-zero operands with an error response.
module calc_arbiter #(
    parameter int EXEC_CYCLES = 1,
    parameter bit FIXED_PRIO  = 1'b0
) (
    input logic   clk,
    input logic   rst,
    calc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic       op;
    } calc_req_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      req_v;
    calc_req_t [1:0] req_pl;
    calc_req_t       sel;
    logic            win, rr_ptr, gnt_q;
    logic            grant, capture, finish, reject;
    logic [1:0]      ack_q, done_q;
    logic [4:0]      res_q;
    logic [2:0]      dp_a_q, dp_b_q;
    logic            dp_s_q;

    assign req_v     = {bus.req1, bus.req0};
    assign req_pl[0] = {bus.a0, bus.b0, bus.op0};
    assign req_pl[1] = {bus.a1, bus.b1, bus.op1};
    assign sel       = req_pl[win];

    // Ties go to rr_ptr in round-robin mode, to client 0 in fixed mode.
    always_comb begin
        win = 1'b0;
        if (req_v == 2'b10)
            win = 1'b1;
        else if (req_v == 2'b11 && !FIXED_PRIO)
            win = rr_ptr;
    end

`ifdef CALC_NEGZERO_CHK_EN
    logic rej_q, err_q;
    assign reject  = (sel.a == 3'b100) || (sel.b == 3'b100);
    assign bus.err = err_q;
`else
    assign reject = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        capture = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: if (|req_v) begin
                grant   = 1'b1;
                cnt_d   = CNT_INIT;
                state_d = reject ? RESP : EXEC;
            end
            EXEC: if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q  <= '0;
            done_q <= '0;
            res_q  <= '0;
            dp_a_q <= '0;
            dp_b_q <= '0;
            dp_s_q <= 1'b0;
            rr_ptr <= 1'b0;
            gnt_q  <= 1'b0;
`ifdef CALC_NEGZERO_CHK_EN
            rej_q  <= 1'b0;
            err_q  <= 1'b0;
`endif
        end else begin
            ack_q  <= '0;
            done_q <= '0;
`ifdef CALC_NEGZERO_CHK_EN
            err_q  <= finish & rej_q;
`endif
            if (grant) begin
                ack_q[win] <= 1'b1;
                gnt_q      <= win;
                if (req_v == 2'b11 && !FIXED_PRIO)
                    rr_ptr <= ~rr_ptr;
`ifdef CALC_NEGZERO_CHK_EN
                rej_q <= reject;
`endif
                // A rejected operand leaves the datapath registers untouched.
                if (reject) begin
                    res_q <= 5'b11111;
                end else begin
                    dp_a_q <= sel.a;
                    dp_b_q <= sel.b;
                    dp_s_q <= sel.op;
                end
            end
            if (capture)
                res_q <= bus.dp_c;
            if (finish)
                done_q[gnt_q] <= 1'b1;
        end
    end

    // busy spans the done cycle so it covers the whole operation from ack to done.
    assign bus.busy  = (state_q != IDLE) || (done_q != 2'b00);
    assign bus.ack0  = ack_q[0];
    assign bus.ack1  = ack_q[1];
    assign bus.done0 = done_q[0];
    assign bus.done1 = done_q[1];
    assign bus.res   = res_q;
    assign bus.dp_a  = dp_a_q;
    assign bus.dp_b  = dp_b_q;
    assign bus.dp_s  = dp_s_q;
endmodule
